// File: rtl/audio_pkg.sv
// Shared audio definitions: sample format and the WM8731 digital-audio-interface
// constants used by both this serializer and the codec-configuration table.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  // WM8731 R7 (digital audio interface format) fields
  localparam logic [1:0] DAIF_FORMAT_RJ  = 2'b00;
  localparam logic [1:0] DAIF_FORMAT_LJ  = 2'b01;
  localparam logic [1:0] DAIF_FORMAT_I2S = 2'b10;
  localparam logic [1:0] DAIF_FORMAT_DSP = 2'b11;
  localparam logic [1:0] DAIF_IWL_16BIT  = 2'b00;
  localparam logic [1:0] DAIF_IWL_20BIT  = 2'b01;
  localparam logic [1:0] DAIF_IWL_24BIT  = 2'b10;
  localparam logic [1:0] DAIF_IWL_32BIT  = 2'b11;
  localparam logic       DAIF_MS_SLAVE   = 1'b0;

  // Codec as slave, I2S, 16-bit words, no BCLK inversion or LR swap.
  localparam logic [8:0] DAIF_CFG = {2'b00, 1'b0, DAIF_MS_SLAVE, 1'b0, 1'b0,
                                     DAIF_IWL_16BIT, DAIF_FORMAT_I2S};

endpackage

// File: rtl/aud_bclk_gen.sv
// Bit-clock generator: divides clk by 2*BCLK_HALF and flags the cycle in which
// the bit clock falls, which is when all serial state is allowed to change.
module aud_bclk_gen #(
  parameter int BCLK_HALF = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             term;

  always_comb begin
    term   = (div_q == DIV_LAST);
    div_d  = term ? '0 : div_q + DIV_W'(1);
    bclk_d = term ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;
  assign fall = term & bclk_q;

endmodule

// File: rtl/aud_dac_serializer.sv
// I2S master serializer for the WM8731 DAC: one stereo sample per frame,
// MSB first, data delayed one bit clock after each LRCK edge.
module aud_dac_serializer
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 16,
  parameter int SLOT_BITS = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int B_W        = $clog2(FRAME_BITS);
  localparam int SREG_W     = 2 * SAMPLE_W;
  localparam logic [B_W-1:0] B_LAST = B_W'(FRAME_BITS - 1);
  localparam logic [B_W-1:0] B_SLOT = B_W'(SLOT_BITS);

  logic fall;

  aud_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
    .clk   (Clk),
    .rst_n (Reset),
    .bclk  (AUD_BCLK),
    .fall  (fall)
  );

  stereo_sample_t    hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [SREG_W-1:0] sreg_q, sreg_d;
  logic [B_W-1:0]    b_q, b_d, b_next;
  logic              lrck_q, lrck_d;
  logic              dat_q, dat_d;
  logic              frame_start_q, frame_start_d;
  logic              underrun_q, underrun_d;
  logic              accept, load;

  // Handshake: a sample transfers on any Clk edge where sample_valid and
  // sample_ready are both high; ready is purely !hold_full, so it never
  // depends on valid and only rises the cycle after a frame load empties hold.
  always_comb begin
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    sreg_d        = sreg_q;
    b_d           = b_q;
    lrck_d        = lrck_q;
    dat_d         = dat_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    b_next = (b_q == B_LAST) ? '0 : b_q + B_W'(1);
    accept = sample_valid & ~hold_full_q;
    load   = fall & (b_next == '0);

    if (fall) begin
      b_d    = b_next;
      lrck_d = (b_next >= B_SLOT);
      dat_d  = sreg_q[SREG_W-1];
      sreg_d = {sreg_q[SREG_W-2:0], 1'b0};
      // The bit leaving on a load edge is the previous frame's right LSB.
      if (load) begin
        frame_start_d = 1'b1;
        if (hold_full_q) begin
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
        end else begin
          sreg_d     = '0;
          underrun_d = 1'b1;
        end
      end
    end

    if (accept) begin
      hold_d.left  = sample_left;
      hold_d.right = sample_right;
      hold_full_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      sreg_q        <= '0;
      b_q           <= B_LAST;
      lrck_q        <= 1'b0;
      dat_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      sreg_q        <= sreg_d;
      b_q           <= b_d;
      lrck_q        <= lrck_d;
      dat_q         <= dat_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign AUD_DACLRCK  = lrck_q;
  assign AUD_DACDAT   = dat_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_aud_dac_serializer.sv
// Bench for aud_dac_serializer: cycle-level reference model feeding a frame
// scoreboard, a serial monitor that reassembles frames on BCLK rises, and a
// per-cycle checker for the bit clock, pulses and ready.
module tb_aud_dac_serializer;

  localparam int BCLK_HALF  = 2;
  localparam int SLOT_BITS  = 16;
  localparam int FRAME_CLK  = 2 * SLOT_BITS * 2 * BCLK_HALF;
  localparam int FIRST_LOAD = 2 * BCLK_HALF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic        sample_ready;
  logic        AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start, underrun;

  aud_dac_serializer #(.BCLK_HALF(BCLK_HALF), .SLOT_BITS(SLOT_BITS)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frames load every FRAME_CLK edges starting FIRST_LOAD edges after release;
  // a frame carries the held sample if one was held before that edge, else 0.
  int          cyc = 0;
  bit          m_full = 0;
  logic [31:0] m_hold = '0;
  bit          e_fs = 0, e_ur = 0, e_bclk = 0;
  bit          m_load, m_take;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cyc = 0; m_full = 0; m_hold = '0;
      e_fs = 0; e_ur = 0; e_bclk = 0;
      exp_q.delete();
    end else begin
      cyc++;
      m_load = (cyc >= FIRST_LOAD) && (((cyc - FIRST_LOAD) % FRAME_CLK) == 0);
      m_take = sample_valid && !m_full;
      e_fs = m_load;
      e_ur = m_load && !m_full;
      if (m_load) begin
        exp_q.push_back(m_full ? m_hold : 32'h0);
        m_full = 0;
      end
      if (m_take) begin
        m_hold = {sample_left, sample_right};
        m_full = 1;
      end
      e_bclk = ((cyc / BCLK_HALF) % 2) == 1;
    end
  end

  // ---------------- per-cycle checker ----------------
  always @(negedge Clk) begin
    chk("bclk", AUD_BCLK, e_bclk);
    chk("frame_start", frame_start, e_fs);
    chk("underrun", underrun, e_ur);
    chk("sample_ready", sample_ready, !m_full);
  end

  // ---------------- serial monitor / scoreboard ----------------
  int          m_rise = 0;
  int          bidx;
  bit          prev_bclk = 0;
  logic [31:0] word = '0;

  always @(negedge Clk) begin
    if (!Reset) begin
      m_rise = 0; prev_bclk = 0; word = '0;
    end else begin
      if (AUD_BCLK && !prev_bclk) begin
        if (m_rise == 0) begin
          chk("lrck_reset_slot", AUD_DACLRCK, 0);
          chk("dat_reset_slot", AUD_DACDAT, 0);
        end else begin
          bidx = (m_rise - 1) % (2 * SLOT_BITS);
          chk("lrck", AUD_DACLRCK, bidx >= SLOT_BITS);
          if (m_rise == 1) begin
            chk("dat_first_b0", AUD_DACDAT, 0);
          end else begin
            word = {word[30:0], AUD_DACDAT};
            if (bidx == 0) begin
              if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL frame_word: got %0h, expected nothing queued", word);
              end else begin
                chk("frame_word", word, exp_q.pop_front());
              end
            end
          end
        end
        m_rise++;
      end
      prev_bclk = AUD_BCLK;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r, input bit jitter);
    int n = 0;
    sample_valid = 1'b1;
    sample_left  = l;
    sample_right = r;
    while (!sample_ready && n < 4 * FRAME_CLK) begin
      @(negedge Clk);
      if (jitter && !sample_ready) begin
        sample_left  = 16'($urandom);
        sample_right = 16'($urandom);
      end
      n++;
    end
    if (!sample_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got ready=0, expected ready=1 within %0d cycles", n);
    end
    @(negedge Clk);
    sample_valid = 1'b0;
  endtask

  task automatic reset_pulse(input int n);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (n) @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_wait;
    #1 Reset = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b1;

    // Known sample ahead of the first load
    send(16'hA5C3, 16'h0F0F, 1'b0);
    idle(2 * FRAME_CLK);

    // Starvation: every frame underruns
    idle(3 * FRAME_CLK);

    // Valid held high, incrementing samples
    for (int i = 1; i <= 4; i++) send(16'(i), ~16'(i), 1'b0);
    idle(2 * FRAME_CLK);

    // Inputs churn while ready is low
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'b1);
    idle(2 * FRAME_CLK);

    // Random gaps and data
    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(0, 300));
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(2 * FRAME_CLK);

    // Mid-frame reset with a sample held
    reset_pulse(2);
    send(16'h1234, 16'h5678, 1'b0);
    send(16'h9ABC, 16'hDEF0, 1'b0);
    n_wait = 0;
    while (cyc < FIRST_LOAD + 4 * BCLK_HALF * 20 + 2 && n_wait < 4 * FRAME_CLK) begin
      @(negedge Clk);
      n_wait++;
    end
    #2 Reset = 1'b0;
    #1;
    chk("async_bclk", AUD_BCLK, 0);
    chk("async_lrck", AUD_DACLRCK, 0);
    chk("async_dat", AUD_DACDAT, 0);
    chk("async_frame_start", frame_start, 0);
    chk("async_underrun", underrun, 0);
    chk("async_ready", sample_ready, 1);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    idle(2 * FRAME_CLK);
    send(16'hBEEF, 16'h8001, 1'b0);
    idle(2 * FRAME_CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
